arb_mux: RTL and testbench

//   Registered N:1 channel multiplexer with per-channel valid/ready handshake. Generalises the
//   2:1 select mux to N channels of W bits. Two modes: fixed select, or round-robin arbitration.

---
 rtl/arb_mux_pkg.sv | 4 +
 rtl/arb_mux_rr_pick.sv | 26 ++
 rtl/arb_mux.sv | 101 ++++++++++
 tb/tb_arb_mux.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: mode encoding shared by arb_mux and its bench
package arb_mux_pkg;
  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} arb_mode_t;
endpackage

// File: rtl/arb_mux_rr_pick.sv
// rr_pick: rotate-priority search, first requester at or after ptr wins
module rr_pick #(
  parameter int N = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int s;
      logic [SELW-1:0] idx;
      s = int'(ptr) + k;
      s = (s >= N) ? s - N : s;
      idx = SELW'(s);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx = idx;
      end
    end
  end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: registered N:1 valid/ready mux, fixed-select or round-robin.
// ARB_MUX_LOCK_EN adds in_last/out_last and packet-locked round-robin grants.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 64,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_src,
  input  logic            out_ready
`ifdef ARB_MUX_LOCK_EN
  ,
  input  logic [N-1:0]    in_last,
  output logic            out_last
`endif
);
  logic [W-1:0] ch [N];
  logic out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [SELW-1:0] out_src_q, out_src_d, rr_ptr_q, rr_ptr_d, rr_idx, g, g_next;
  logic rr_gnt, rr_mode, can_load, grant, accept;
  logic [N-1:0] sel_oh;
`ifdef ARB_MUX_LOCK_EN
  logic lock_q, lock_d, out_last_q, out_last_d;
  logic [SELW-1:0] lock_idx_q, lock_idx_d;
`endif
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch[i] = in_data[i*W +: W];
  end
  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .req      (in_valid),
    .ptr      (rr_ptr_q),
    .gnt_valid(rr_gnt),
    .gnt_idx  (rr_idx)
  );
  always_comb begin
    rr_mode = arb_mode_t'(mode) == MODE_RR;
    can_load = !out_valid_q || out_ready;
    // out-of-range sel shifts the one-hot to zero, so it never grants
    sel_oh = N'(1) << sel;
    g = rr_mode ? rr_idx : sel;
    grant = rr_mode ? rr_gnt : |(in_valid & sel_oh);
`ifdef ARB_MUX_LOCK_EN
    g = (rr_mode && lock_q) ? lock_idx_q : g;
    grant = (rr_mode && lock_q) ? in_valid[lock_idx_q] : grant;
`endif
    accept = grant && can_load && !rst;
    in_ready = accept ? N'(1) << g : '0;
    g_next = (g == SELW'(N - 1)) ? '0 : g + 1'b1;
    out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d = accept ? ch[g] : out_data_q;
    out_src_d = accept ? g : out_src_q;
    rr_ptr_d = (accept && rr_mode) ? g_next : rr_ptr_q;
`ifdef ARB_MUX_LOCK_EN
    rr_ptr_d = (accept && rr_mode && !in_last[g]) ? rr_ptr_q : rr_ptr_d;
    lock_d = !rr_mode ? 1'b0 : (accept ? !in_last[g] : lock_q);
    lock_idx_d = accept ? g : lock_idx_q;
    out_last_d = accept ? in_last[g] : out_last_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_src_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_src_q <= out_src_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
`ifdef ARB_MUX_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
      lock_idx_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      lock_idx_q <= lock_idx_d;
      out_last_q <= out_last_d;
    end
  end
  assign out_last = out_last_q;
`endif
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_src = out_src_q;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed checks of arb_mux (N=4,W=64 and N=3,W=8 instances)
module tb_arb_mux;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic mode, out_ready, out_valid;
  logic [1:0] sel, out_src;
  logic [3:0] in_valid, in_ready;
  logic [255:0] in_data;
  logic [63:0] out_data;
  logic mode3, out_ready3, out_valid3;
  logic [1:0] sel3, out_src3;
  logic [2:0] in_valid3, in_ready3;
  logic [23:0] in_data3;
  logic [7:0] out_data3;
`ifdef ARB_MUX_LOCK_EN
  logic [3:0] in_last;
  logic [2:0] in_last3;
  logic out_last, out_last3;
`endif
  logic [63:0] dv [4];
  logic [7:0] dv3 [3];
  int pass_cnt = 0, total_cnt = 0;

  arb_mux #(.N(4), .W(64)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
`ifdef ARB_MUX_LOCK_EN
    , .in_last(in_last), .out_last(out_last)
`endif
  );
  arb_mux #(.N(3), .W(8)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3), .out_src(out_src3),
    .out_ready(out_ready3)
`ifdef ARB_MUX_LOCK_EN
    , .in_last(in_last3), .out_last(out_last3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got %b want 0000", in_ready); else pass_cnt++;
    total_cnt++; if (in_ready3 !== 3'b000) $display("FAIL reset_in_ready3 got %b want 000", in_ready3); else pass_cnt++;
    step();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 64'h0) $display("FAIL reset_out_data got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if (out_src !== 2'd0) $display("FAIL reset_out_src got %0d want 0", out_src); else pass_cnt++;
    total_cnt++; if (out_valid3 !== 1'b0) $display("FAIL reset_out_valid3 got %b want 0", out_valid3); else pass_cnt++;
    in_valid = 4'b0000; in_valid3 = 3'b000;
    rst = 1'b0;
    step();
  endtask

  task automatic test_mode0();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 4'b0100) $display("FAIL m0_in_ready got %b want 0100", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL m0_out_valid got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== dv[2]) $display("FAIL m0_out_data got %h want %h", out_data, dv[2]); else pass_cnt++;
    total_cnt++; if (out_src !== 2'd2) $display("FAIL m0_out_src got %0d want 2", out_src); else pass_cnt++;
    sel = 2'd1; in_valid = 4'b0101;
    #1;
    total_cnt++; if (in_ready !== 4'b0000) $display("FAIL m0_invalid_sel got %b want 0000", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL m0_drain_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== dv[2]) $display("FAIL m0_drain_data got %h want %h", out_data, dv[2]); else pass_cnt++;
    total_cnt++; if (out_src !== 2'd2) $display("FAIL m0_drain_src got %0d want 2", out_src); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 4'b0001) $display("FAIL rr_first_ready got %b want 0001", in_ready); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL rr_valid[%0d] got %b want 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_src !== 2'(i % 4)) $display("FAIL rr_src[%0d] got %0d want %0d", i, out_src, i % 4); else pass_cnt++;
      total_cnt++; if (out_data !== dv[i%4]) $display("FAIL rr_data[%0d] got %h want %h", i, out_data, dv[i%4]); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== dv[3]) $display("FAIL bp_data[%0d] got %h want %h", i, out_data, dv[3]); else pass_cnt++;
      total_cnt++; if (out_src !== 2'd3) $display("FAIL bp_src[%0d] got %0d want 3", i, out_src); else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 4'b0001) $display("FAIL bp_release_ready got %b want 0001", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_release_valid got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_src !== 2'd0) $display("FAIL bp_release_src got %0d want 0", out_src); else pass_cnt++;
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_n3_wrap();
    mode3 = 1'b1; in_valid3 = 3'b001; out_ready3 = 1'b1;
    step();
    total_cnt++; if (out_src3 !== 2'd0) $display("FAIL n3_seed_src got %0d want 0", out_src3); else pass_cnt++;
    in_valid3 = 3'b101;
    #1;
    total_cnt++; if (in_ready3 !== 3'b100) $display("FAIL n3_ready_a got %b want 100", in_ready3); else pass_cnt++;
    step();
    total_cnt++; if (out_src3 !== 2'd2) $display("FAIL n3_src_a got %0d want 2", out_src3); else pass_cnt++;
    total_cnt++; if (out_data3 !== dv3[2]) $display("FAIL n3_data_a got %h want %h", out_data3, dv3[2]); else pass_cnt++;
    total_cnt++; if (in_ready3 !== 3'b001) $display("FAIL n3_ready_b got %b want 001", in_ready3); else pass_cnt++;
    step();
    total_cnt++; if (out_src3 !== 2'd0) $display("FAIL n3_src_b got %0d want 0", out_src3); else pass_cnt++;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    total_cnt++; if (in_ready3 !== 3'b000) $display("FAIL n3_sel_oor_ready got %b want 000", in_ready3); else pass_cnt++;
    step();
    total_cnt++; if (out_valid3 !== 1'b0) $display("FAIL n3_sel_oor_valid got %b want 0", out_valid3); else pass_cnt++;
    in_valid3 = 3'b000;
  endtask

`ifdef ARB_MUX_LOCK_EN
  task automatic test_lock();
    logic [3:0] vv [6];
    logic [3:0] ll [6];
    logic ev [6];
    logic [1:0] es [6];
    logic el [6];
    in_last3 = 3'b111;
    rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1; mode = 1'b1;
    step();
    rst = 1'b0;
    vv = '{4'b0001, 4'b0111, 4'b0111, 4'b0101, 4'b0111, 4'b0111};
    ll = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    ev = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    es = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    el = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      in_valid = vv[i]; in_last = ll[i];
      step();
      total_cnt++; if (out_valid !== ev[i]) $display("FAIL lock_valid[%0d] got %b want %b", i, out_valid, ev[i]); else pass_cnt++;
      total_cnt++; if (out_src !== es[i]) $display("FAIL lock_src[%0d] got %0d want %0d", i, out_src, es[i]); else pass_cnt++;
      total_cnt++; if (out_last !== el[i]) $display("FAIL lock_last[%0d] got %b want %b", i, out_last, el[i]); else pass_cnt++;
    end
    in_valid = 4'b0000;
  endtask
`endif

  initial begin
    dv[0] = 64'hAAAA_0000_1111_0000; dv[1] = 64'hBBBB_0001_2222_0001;
    dv[2] = 64'hCCCC_0002_3333_0002; dv[3] = 64'hDDDD_0003_4444_0003;
    dv3[0] = 8'h30; dv3[1] = 8'h31; dv3[2] = 8'h32;
    in_data = {dv[3], dv[2], dv[1], dv[0]};
    in_data3 = {dv3[2], dv3[1], dv3[0]};
`ifdef ARB_MUX_LOCK_EN
    in_last = 4'b1111; in_last3 = 3'b111;
`endif
    test_reset();
    test_mode0();
    test_round_robin();
    test_back_to_back();
    test_n3_wrap();
`ifdef ARB_MUX_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
